pipe_hazard_ctrl: RTL

Parametrised pipeline sequencing and hazard controller for the MIPS pipeline core. It replaces the fixed enable ramp and the ad-hoc branch-after-load stall logic with one block. The block generates the PC write enable and per-register enable/bubble strobes for an N-stage pipeline, and adds instruction- and data-memory wait-state handling with a bounded data-memory wait timeout. It sits beside the pipeline registers in the core top level and is purely control: it carries no datapath.

---
 rtl/pipe_hazard_ctrl_pkg.sv | 28 ++
 rtl/pipe_hazard_ctrl_hazard_detect.sv | 43 ++++
 rtl/pipe_hazard_ctrl.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/pipe_hazard_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// pipe_hazard_ctrl_pkg
// Shared definitions for the pipeline sequencing / hazard controller.
//   - Controller state encoding (FILL, RUN, MEM_WAIT, HALT) as sized constants.
//   - NOP instruction word loaded into a pipeline register on a bubble.
//   - Hazard flag bundle passed from the detector to the controller FSM.
// No ports (package).
// -----------------------------------------------------------------------------
package pipe_hazard_ctrl_pkg;

   typedef logic [1:0] state_t;

   localparam state_t ST_FILL     = 2'd0;
   localparam state_t ST_RUN      = 2'd1;
   localparam state_t ST_MEM_WAIT = 2'd2;
   localparam state_t ST_HALT     = 2'd3;

   // Instruction word a bubbled register loads (GPR write disabled).
   localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

   // Raw hazard conditions; priority is resolved by the controller.
   typedef struct packed {
      logic dmem;   // data access in MEM not completing this cycle
      logic ld_br;  // branch in ID needs the result of the load in EXE
      logic imem;   // instruction fetch not completing this cycle
   } hazard_t;

endpackage

// File: rtl/pipe_hazard_ctrl_hazard_detect.sv
// -----------------------------------------------------------------------------
// pipe_hazard_ctrl_hazard_detect
// Purely combinational hazard detection for pipe_hazard_ctrl.
// Ports:
//   id_is_branch_i        ID instruction resolves a branch in ID
//   id_rs_i, id_rt_i      ID source register addresses
//   exe_is_load_i         EXE instruction is a load
//   exe_waddr_i           EXE load destination register
//   imem_ready_i          instruction fetch completes this cycle
//   dmem_req_i            MEM stage accesses data memory
//   dmem_ready_i          data access completes this cycle
//   hazard_o              raw (unprioritised) hazard flags
// -----------------------------------------------------------------------------
module pipe_hazard_ctrl_hazard_detect
   import pipe_hazard_ctrl_pkg::*;
#(
   parameter int REG_ADDR_W = 5
) (
   input  logic                  id_is_branch_i,
   input  logic [REG_ADDR_W-1:0] id_rs_i,
   input  logic [REG_ADDR_W-1:0] id_rt_i,
   input  logic                  exe_is_load_i,
   input  logic [REG_ADDR_W-1:0] exe_waddr_i,
   input  logic                  imem_ready_i,
   input  logic                  dmem_req_i,
   input  logic                  dmem_ready_i,
   output hazard_t               hazard_o
);

   logic waddr_live;
   logic src_match;

   // $zero is never really written, so a load targeting it cannot feed a branch.
   assign waddr_live = (exe_waddr_i != '0);
   assign src_match  = (exe_waddr_i == id_rs_i) || (exe_waddr_i == id_rt_i);

   always_comb begin
      hazard_o.dmem  = dmem_req_i & ~dmem_ready_i;
      hazard_o.ld_br = id_is_branch_i & exe_is_load_i & waddr_live & src_match;
      hazard_o.imem  = ~imem_ready_i;
   end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// pipe_hazard_ctrl
// Pipeline sequencing and hazard controller for an N-stage MIPS pipeline.
// Generates the PC write enable and per-pipeline-register load/bubble strobes,
// ramps the pipeline up after reset (FILL), and handles instruction-memory and
// data-memory wait states with a bounded data-memory wait timeout (HALT).
// Control only; no datapath.
//
// Optional feature: define HAZARD_PERF_CNT_EN to add the stall_cycles_o
// performance counter port.
//
// Ports:
//   clk_i            core clock, rising edge
//   reset_i          synchronous active-high reset
//   ena_i            global run enable; low forces all enables to 0, state holds
//   id_is_branch_i   ID instruction resolves a branch in ID
//   id_rs_i/id_rt_i  ID source register addresses
//   exe_is_load_i    EXE instruction is a load
//   exe_waddr_i      EXE load destination register
//   imem_ready_i     instruction fetch completes this cycle
//   dmem_req_i       MEM stage accesses data memory
//   dmem_ready_i     data access completes this cycle
//   pc_we_o          PC write enable
//   pipe_ena_o       load enable of pipeline register i (between stage i, i+1)
//   pipe_bubble_o    with pipe_ena_o[i]: register i loads a NOP
//   mem_timeout_o    sticky data-memory timeout flag
//   stall_cycles_o   stall cycle counter (HAZARD_PERF_CNT_EN only)
// -----------------------------------------------------------------------------
module pipe_hazard_ctrl
   import pipe_hazard_ctrl_pkg::*;
#(
   parameter int NUM_STAGES   = 5,
   parameter int REG_ADDR_W   = 5,
   parameter int MAX_MEM_WAIT = 15
) (
   input  logic                  clk_i,
   input  logic                  reset_i,
   input  logic                  ena_i,
   input  logic                  id_is_branch_i,
   input  logic [REG_ADDR_W-1:0] id_rs_i,
   input  logic [REG_ADDR_W-1:0] id_rt_i,
   input  logic                  exe_is_load_i,
   input  logic [REG_ADDR_W-1:0] exe_waddr_i,
   input  logic                  imem_ready_i,
   input  logic                  dmem_req_i,
   input  logic                  dmem_ready_i,
   output logic                  pc_we_o,
   output logic [NUM_STAGES-2:0] pipe_ena_o,
   output logic [NUM_STAGES-2:0] pipe_bubble_o,
   output logic                  mem_timeout_o
`ifdef HAZARD_PERF_CNT_EN
   ,
   output logic [31:0]           stall_cycles_o
`endif
);

   localparam int NR     = NUM_STAGES - 1;
   localparam int FILL_W = (NUM_STAGES > 2) ? $clog2(NUM_STAGES - 1) : 1;
   localparam int WAIT_W = $clog2(MAX_MEM_WAIT + 1);

   localparam logic [FILL_W-1:0] FILL_LAST  = FILL_W'(NUM_STAGES - 2);
   localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(MAX_MEM_WAIT);
   localparam logic [NR-1:0]     BUB_IF_ID  = NR'(1);
   localparam logic [NR-1:0]     BUB_ID_EX  = NR'(2);

   state_t            state_q, state_d;
   logic [FILL_W-1:0] fill_cnt_q, fill_cnt_d;
   logic              fill_done_q, fill_done_d;
   logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
   logic              timeout_q, timeout_d;

   hazard_t           haz;
   logic [NR-1:0]     fill_mask;
   logic              freeze;
   logic              stall;
   logic [WAIT_W-1:0] wait_base;
   logic [WAIT_W-1:0] wait_inc;
   logic              pc_we;
   logic [NR-1:0]     ena_vec;
   logic [NR-1:0]     bub_vec;

   pipe_hazard_ctrl_hazard_detect #(
      .REG_ADDR_W (REG_ADDR_W)
   ) u_hazard_detect (
      .id_is_branch_i (id_is_branch_i),
      .id_rs_i        (id_rs_i),
      .id_rt_i        (id_rt_i),
      .exe_is_load_i  (exe_is_load_i),
      .exe_waddr_i    (exe_waddr_i),
      .imem_ready_i   (imem_ready_i),
      .dmem_req_i     (dmem_req_i),
      .dmem_ready_i   (dmem_ready_i),
      .hazard_o       (haz)
   );

   // During the ramp only registers 0..fill_cnt hold meaningful instructions.
   always_comb begin
      for (int i = 0; i < NR; i++) begin
         fill_mask[i] = (FILL_W'(i) <= fill_cnt_q);
      end
   end

   always_comb begin
      // NOTE: every variable gets a default first so no path leaves it
      // unassigned; otherwise synthesis infers a latch.
      state_d     = state_q;
      fill_cnt_d  = fill_cnt_q;
      fill_done_d = fill_done_q;
      wait_cnt_d  = wait_cnt_q;
      timeout_d   = timeout_q;
      freeze      = 1'b0;
      stall       = 1'b0;
      wait_base   = '0;
      wait_inc    = '0;
      pc_we       = 1'b0;
      ena_vec     = '0;
      bub_vec     = '0;

      // ena_i low (or HALT) leaves every enable at 0 and all state unchanged.
      if (ena_i && (state_q != ST_HALT)) begin
         // Inside MEM_WAIT the access is still outstanding, so only ready matters.
         freeze = (state_q == ST_MEM_WAIT) ? ~dmem_ready_i : haz.dmem;

         if (freeze) begin
            // The first frozen cycle (entry from FILL/RUN) is wait cycle 1.
            wait_base = (state_q == ST_MEM_WAIT) ? wait_cnt_q : '0;
            wait_inc  = (wait_base == WAIT_LIMIT) ? wait_base : wait_base + WAIT_W'(1);
            wait_cnt_d = wait_inc;
            if (wait_inc == WAIT_LIMIT) begin
               state_d   = ST_HALT;
               timeout_d = 1'b1;
            end else begin
               state_d   = ST_MEM_WAIT;
            end
         end else begin
            wait_cnt_d = '0;

            if (haz.ld_br) begin
               // Hold IF/ID, inject a NOP into ID/EXE, let the rest drain.
               ena_vec    = '1;
               ena_vec[0] = 1'b0;
               bub_vec    = BUB_ID_EX;
            end else if (haz.imem) begin
               // No new instruction: IF/ID takes a NOP, the rest advances.
               ena_vec = '1;
               bub_vec = BUB_IF_ID;
            end else begin
               pc_we   = 1'b1;
               ena_vec = '1;
            end
            stall = haz.ld_br | haz.imem;

            if (!fill_done_q) begin
               ena_vec = ena_vec & fill_mask;
               bub_vec = bub_vec & fill_mask;
               if (stall) begin
                  state_d = ST_FILL;
               end else if (fill_cnt_q == FILL_LAST) begin
                  fill_done_d = 1'b1;
                  state_d     = ST_RUN;
               end else begin
                  fill_cnt_d = fill_cnt_q + FILL_W'(1);
                  state_d    = ST_FILL;
               end
            end else begin
               state_d = ST_RUN;
            end
         end
      end
   end

   always_ff @(posedge clk_i) begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples the pre-edge values regardless of statement order.
      if (reset_i) begin
         state_q     <= ST_FILL;
         fill_cnt_q  <= '0;
         fill_done_q <= 1'b0;
         wait_cnt_q  <= '0;
         timeout_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         fill_cnt_q  <= fill_cnt_d;
         fill_done_q <= fill_done_d;
         wait_cnt_q  <= wait_cnt_d;
         timeout_q   <= timeout_d;
      end
   end

   // Outputs are forced low while reset is asserted, before the first edge.
   assign pc_we_o       = pc_we & ~reset_i;
   assign pipe_ena_o    = reset_i ? '0 : ena_vec;
   assign pipe_bubble_o = reset_i ? '0 : bub_vec;
   assign mem_timeout_o = timeout_q & ~reset_i;

`ifdef HAZARD_PERF_CNT_EN
   logic [31:0] stall_cnt_q, stall_cnt_d;

   // HALT is excluded: its zero pc_we is a dead pipeline, not a stall.
   always_comb begin
      stall_cnt_d = stall_cnt_q;
      if (ena_i && (state_q != ST_HALT) && !pc_we) begin
         stall_cnt_d = stall_cnt_q + 32'd1;
      end
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         stall_cnt_q <= '0;
      end else begin
         stall_cnt_q <= stall_cnt_d;
      end
   end

   assign stall_cycles_o = reset_i ? '0 : stall_cnt_q;
`endif

endmodule
